// File: rtl/stream_sink_checker_pkg.sv
// ============================================================================
// Module   : stream_sink_checker_pkg
// Purpose  : Shared types and float_24_8 field accessors for the stream sink
//            checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_sink_checker_pkg;

    localparam int c_F24_WIDTH = 32;
    localparam int c_F24_EXP_W = 8;
    localparam int c_F24_MAN_W = 23;

    typedef enum logic [1:0] {
        SNK_IDLE = 2'd0,
        SNK_SYNC = 2'd1,
        SNK_RUN  = 2'd2,
        SNK_DONE = 2'd3
    } sink_state_t;

    // Raw layout: {sign, exponent[7:0], mantissa[22:0]}
    function automatic logic f24_sign(input logic [c_F24_WIDTH-1:0] w);
        return w[c_F24_WIDTH-1];
    endfunction

    function automatic logic [c_F24_EXP_W-1:0] f24_exp(input logic [c_F24_WIDTH-1:0] w);
        return w[c_F24_WIDTH-2 -: c_F24_EXP_W];
    endfunction

    // Mantissa widened to 24 bits so differences are taken unsigned at that width
    function automatic logic [23:0] f24_mant(input logic [c_F24_WIDTH-1:0] w);
        return {1'b0, w[c_F24_MAN_W-1:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_sink_checker_ready_gen.sv
// ============================================================================
// Module   : stream_sink_checker_ready_gen
// Purpose  : Back-pressure generator: free-running 3-bit slot counter selecting
//            a bit of the ready mask, with a registered ready output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_sink_checker_ready_gen (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_active,
    input  logic [7:0] i_rdy_mask,
    output logic       o_data_rdy
);

    logic [2:0] r_slot_q;
    logic [2:0] w_slot_d;
    logic       r_rdy_q;
    logic       w_rdy_d;

    // i_active reflects the next state, so ready drops on the same edge the
    // checker enters IDLE or DONE
    always_comb begin
        w_slot_d = 3'd0;
        w_rdy_d  = 1'b0;
        if (i_active) begin
            w_slot_d = r_slot_q + 3'd1;
            w_rdy_d  = i_rdy_mask[r_slot_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_q <= 3'd0;
            r_rdy_q  <= 1'b0;
        end else begin
            r_slot_q <= w_slot_d;
            r_rdy_q  <= w_rdy_d;
        end
    end

    assign o_data_rdy = r_rdy_q;

endmodule

`default_nettype wire

// File: rtl/stream_sink_checker.sv
// ============================================================================
// Module   : stream_sink_checker
// Purpose  : Receive end of the float_24_8 vld/rdy/fst stream; compares each
//            accepted word with an expected frame and reports error/frame counts.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_sink_checker
    import stream_sink_checker_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 72,
    parameter int FRAMES  = 64,
    parameter int TOL_LSB = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         data,
    input  logic                     data_fst,
    input  logic                     data_vld,
    output logic                     data_rdy,
    input  logic [7:0]               rdy_mask,
    input  logic                     exp_wr_en,
    input  logic [$clog2(DEPTH)-1:0] exp_wr_addr,
    input  logic [WIDTH-1:0]         exp_wr_data,
    output logic                     mismatch,
    output logic [15:0]              err_count,
    output logic [31:0]              first_err,
    output logic [15:0]              frame_count,
    output logic                     done
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];

    sink_state_t      r_state_q, w_state_d;
    logic [c_AW-1:0]  r_idx_q, w_idx_d;
    logic [15:0]      r_frame_q, w_frame_d;
    logic [15:0]      r_err_q, w_err_d;
    logic [31:0]      r_first_q, w_first_d;
    logic             r_mis_q, w_mis_d;
    logic             r_done_q, w_done_d;

    logic             w_xfer, w_take, w_frm_err, w_data_pass, w_fail, w_active_d;
    logic [c_AW-1:0]  w_eff_idx;
    logic [WIDTH-1:0] w_exp_word;
    logic [31:0]      w_act_raw, w_exp_raw;
    logic [23:0]      w_mant_a, w_mant_b, w_mant_diff;

    // Writes land at the clock edge, so a same-cycle compare sees the old word
    always_ff @(posedge clk) begin
        if (exp_wr_en && (int'(exp_wr_addr) < DEPTH)) begin
            r_mem[exp_wr_addr] <= exp_wr_data;
        end
    end

    always_comb begin
        w_xfer      = data_vld & data_rdy;
        w_eff_idx   = data_fst ? '0 : r_idx_q;
        w_exp_word  = r_mem[w_eff_idx];
        w_act_raw   = 32'(data);
        w_exp_raw   = 32'(w_exp_word);
        w_mant_a    = f24_mant(w_act_raw);
        w_mant_b    = f24_mant(w_exp_raw);
        w_mant_diff = (w_mant_a >= w_mant_b) ? (w_mant_a - w_mant_b) : (w_mant_b - w_mant_a);
        w_data_pass = (data == w_exp_word) ||
                      ((f24_sign(w_act_raw) == f24_sign(w_exp_raw)) &&
                       (f24_exp(w_act_raw) == f24_exp(w_exp_raw)) &&
                       (w_mant_diff <= 24'(TOL_LSB)));
        w_frm_err   = (r_state_q == SNK_RUN) &&
                      (data_fst ? (r_idx_q != '0) : (r_idx_q == '0));
        // In SYNC only a first-of-frame word is taken; the rest are dropped
        w_take      = w_xfer && ((r_state_q == SNK_RUN) ||
                                 ((r_state_q == SNK_SYNC) && data_fst));
        w_fail      = w_take && (w_frm_err || !w_data_pass);
    end

    always_comb begin
        w_state_d = r_state_q;
        w_idx_d   = r_idx_q;
        w_frame_d = r_frame_q;
        w_err_d   = r_err_q;
        w_first_d = r_first_q;
        w_mis_d   = 1'b0;
        w_done_d  = r_done_q;

        case (r_state_q)
            SNK_IDLE: begin
                if (enable) begin
                    w_state_d = SNK_SYNC;
                end
            end
            SNK_SYNC, SNK_RUN: begin
                if (w_take) begin
                    w_state_d = SNK_RUN;
                    if (w_eff_idx == c_AW'(DEPTH - 1)) begin
                        w_idx_d   = '0;
                        w_frame_d = r_frame_q + 16'd1;
                        if (w_frame_d == 16'(FRAMES)) begin
                            w_state_d = SNK_DONE;
                            w_done_d  = 1'b1;
                        end
                    end else begin
                        w_idx_d = w_eff_idx + c_AW'(1);
                    end
                end
            end
            default: begin
            end
        endcase

        // first_err records where the stream was when the failure was seen
        if (w_fail) begin
            w_mis_d = 1'b1;
            if (r_err_q != 16'hFFFF) begin
                w_err_d = r_err_q + 16'd1;
            end
            if (r_err_q == 16'd0) begin
                w_first_d = {r_frame_q, 16'(r_idx_q)};
            end
        end

        w_active_d = (w_state_d == SNK_SYNC) || (w_state_d == SNK_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= SNK_IDLE;
            r_idx_q   <= '0;
            r_frame_q <= 16'd0;
            r_err_q   <= 16'd0;
            r_first_q <= 32'd0;
            r_mis_q   <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_idx_q   <= w_idx_d;
            r_frame_q <= w_frame_d;
            r_err_q   <= w_err_d;
            r_first_q <= w_first_d;
            r_mis_q   <= w_mis_d;
            r_done_q  <= w_done_d;
        end
    end

    stream_sink_checker_ready_gen u_sink_ready_gen (
        .clk        (clk),
        .reset      (reset),
        .i_active   (w_active_d),
        .i_rdy_mask (rdy_mask),
        .o_data_rdy (data_rdy)
    );

    assign mismatch    = r_mis_q;
    assign err_count   = r_err_q;
    assign first_err   = r_first_q;
    assign frame_count = r_frame_q;
    assign done        = r_done_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_sink_checker.sv
// ============================================================================
// Module   : tb_stream_sink_checker
// Purpose  : Directed scoreboard bench for stream_sink_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_stream_sink_checker;

    localparam int DEPTH  = 72;
    localparam int FRAMES = 64;
    localparam int AW     = 7;

    logic          clk = 1'b0;
    logic          reset, enable, data_fst, data_vld, exp_wr_en;
    logic [31:0]   data, exp_wr_data;
    logic [7:0]    rdy_mask;
    logic [AW-1:0] exp_wr_addr;

    wire           data_rdy, mismatch, done;
    wire  [15:0]   err_count, frame_count;
    wire  [31:0]   first_err;
    wire           u1_data_rdy, u1_mismatch, u1_done;
    wire  [15:0]   u1_err_count, u1_frame_count;
    wire  [31:0]   u1_first_err;

    typedef struct packed {
        logic        mis;
        logic [15:0] err;
        logic [15:0] frm;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   total = 0;
    int   bad   = 0;
    int   e_err = 0;
    int   e_frm = 0;
    int   cnt   = 0;
    logic xfer_seen = 1'b0;

    always #5 clk = ~clk;

    stream_sink_checker #(.WIDTH(32), .DEPTH(DEPTH), .FRAMES(FRAMES), .TOL_LSB(0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .data(data), .data_fst(data_fst),
        .data_vld(data_vld), .data_rdy(data_rdy), .rdy_mask(rdy_mask),
        .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
        .mismatch(mismatch), .err_count(err_count), .first_err(first_err),
        .frame_count(frame_count), .done(done)
    );

    stream_sink_checker #(.WIDTH(32), .DEPTH(DEPTH), .FRAMES(FRAMES), .TOL_LSB(1)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .data(data), .data_fst(data_fst),
        .data_vld(data_vld), .data_rdy(u1_data_rdy), .rdy_mask(rdy_mask),
        .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
        .mismatch(u1_mismatch), .err_count(u1_err_count), .first_err(u1_first_err),
        .frame_count(u1_frame_count), .done(u1_done)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'h4100_0000 + 32'(i) * 32'h0001_0010;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: every accepted word must produce the queued response one cycle later
    always @(posedge clk) xfer_seen <= (data_vld === 1'b1) && (data_rdy === 1'b1) && !reset;

    always @(negedge clk) begin
        if (xfer_seen) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: got unexpected transfer want none");
            end else begin
                m_e = sb.pop_front();
                check("mismatch", 32'(mismatch), 32'(m_e.mis));
                check("err_count", 32'(err_count), 32'(m_e.err));
                check("frame_count", 32'(frame_count), 32'(m_e.frm));
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic f, input logic mis, input logic fin);
        int   waited;
        exp_t ne;
        waited   = 0;
        data     = d;
        data_fst = f;
        data_vld = 1'b1;
        @(negedge clk);
        while (data_rdy !== 1'b1 && waited < 32) begin
            @(negedge clk);
            waited++;
        end
        if (data_rdy !== 1'b1) begin
            total++;
            bad++;
            data_vld = 1'b0;
            $display("FAIL send_timeout: got rdy=%b want 1", data_rdy);
        end else begin
            if (mis) e_err++;
            if (fin) e_frm++;
            ne.mis = mis;
            ne.err = 16'(e_err);
            ne.frm = 16'(e_frm);
            sb.push_back(ne);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int corrupt_idx);
        for (int i = 0; i < DEPTH; i++) begin
            send(pat(i) + ((i == corrupt_idx) ? 32'd1 : 32'd0), i == 0, i == corrupt_idx,
                 i == DEPTH - 1);
        end
    endtask

    task automatic do_reset();
        data_vld = 1'b0;
        enable   = 1'b0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        e_err = 0;
        e_frm = 0;
    endtask

    task automatic start();
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic settle();
        data_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; data = '0; data_fst = 1'b0; data_vld = 1'b0;
        rdy_mask = 8'hFF; exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_wr_en   = 1'b1;
            exp_wr_addr = AW'(i);
            exp_wr_data = pat(i);
            @(posedge clk);
            #1;
        end
        exp_wr_en = 1'b0;

        // Reset state and IDLE hold without enable
        do_reset();
        check("rst_err", 32'(err_count), 32'd0);
        check("rst_frame", 32'(frame_count), 32'd0);
        check("rst_first", first_err, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mis", 32'(mismatch), 32'd0);
        check("rst_rdy", 32'(data_rdy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("idle_rdy", 32'(data_rdy), 32'd0);

        // Full run: 64 exact frames, then DONE with ready low
        start();
        for (int f = 0; f < FRAMES; f++) send_frame(-1);
        settle();
        check("full_err", 32'(err_count), 32'd0);
        check("full_frame", 32'(frame_count), 32'd64);
        check("full_done", 32'(done), 32'd1);
        check("full_rdy", 32'(data_rdy), 32'd0);
        check("full_tol_done", 32'(u1_done), 32'd1);
        data_vld = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("done_hold_rdy", 32'(data_rdy), 32'd0);
        check("done_hold_frame", 32'(frame_count), 32'd64);

        // Mid-frame start, then corruption at frame 2 idx 5
        do_reset();
        start();
        for (int i = 69; i < 72; i++) send(pat(i), 1'b0, 1'b0, 1'b0);
        send_frame(-1);
        send_frame(-1);
        send_frame(5);
        settle();
        check("corrupt_err", 32'(err_count), 32'd1);
        check("corrupt_first", first_err, 32'h0002_0005);
        check("corrupt_frame", 32'(frame_count), 32'd3);
        check("tol1_err", 32'(u1_err_count), 32'd0);
        check("tol1_frame", 32'(u1_frame_count), 32'd3);

        // Alternating back-pressure with valid held high
        do_reset();
        rdy_mask = 8'b0101_0101;
        start();
        fork
            begin
                send_frame(-1);
                send_frame(-1);
                data_vld = 1'b0;
            end
            begin
                repeat (20) @(posedge clk);
                cnt = 0;
                for (int c = 0; c < 64; c++) begin
                    @(posedge clk);
                    if (data_vld && data_rdy) cnt++;
                end
                check("bp_rate", 32'(cnt), 32'd32);
            end
        join
        settle();
        check("bp_frame", 32'(frame_count), 32'd2);
        check("bp_err", 32'(err_count), 32'd0);
        rdy_mask = 8'hFF;

        // Framing error: fst at idx 40 of frame 1
        do_reset();
        start();
        send_frame(-1);
        for (int i = 0; i < 40; i++) send(pat(i), i == 0, 1'b0, 1'b0);
        send(pat(0), 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < DEPTH; i++) send(pat(i), 1'b0, 1'b0, i == DEPTH - 1);
        settle();
        check("frm_err", 32'(err_count), 32'd1);
        check("frm_frame", 32'(frame_count), 32'd2);
        check("frm_first", first_err, 32'h0001_0028);

        // Reset at idx 30 of frame 1, then clean restart
        do_reset();
        start();
        send_frame(-1);
        for (int i = 0; i < 30; i++) send(pat(i), i == 0, 1'b0, 1'b0);
        do_reset();
        check("midrst_sb", 32'(sb.size()), 32'd0);
        check("midrst_frame", 32'(frame_count), 32'd0);
        check("midrst_err", 32'(err_count), 32'd0);
        check("midrst_rdy", 32'(data_rdy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("midrst_idle_rdy", 32'(data_rdy), 32'd0);
        start();
        send_frame(-1);
        send_frame(-1);
        settle();
        check("restart_frame", 32'(frame_count), 32'd2);
        check("restart_err", 32'(err_count), 32'd0);
        check("restart_first", first_err, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
